button_conditioner: RTL

Converts raw, asynchronous, active-low board pushbuttons into clean synchronous events for the sum datapath and its test harness. It sits directly upstream of the harness and replaces raw Button0/Button2 use. Per button it provides a debounced level, one-cycle press and release pulses, and a one-shot long-press pulse. Downstream uses press_pulse as the step/go strobe and long_pulse as the harness restart.

---
 rtl/button_conditioner.sv | 133 +++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Conditions raw active-low pushbuttons into a debounced level plus press,
// release and one-shot long-press pulses, one independent channel per button.
module button_conditioner #(
    parameter int unsigned N_BTN           = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned LONG_CYCLES     = 50000000,
    parameter int unsigned CNT_W           = 26
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_BTN-1:0] button_l,
    output logic [N_BTN-1:0] pressed,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] long_pulse
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYCLES);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("button_conditioner: DEBOUNCE_CYCLES must be >= 2");
    end
    if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
        $error("button_conditioner: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
    end
    if ((64'(LONG_CYCLES) >> CNT_W) != 64'd0) begin : g_bad_width
        $error("button_conditioner: CNT_W too narrow for LONG_CYCLES");
    end

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        logic             s1;
        logic             s2;
        logic             active;
        state_t           state;
        logic [CNT_W-1:0] dcnt;
        logic [CNT_W-1:0] lcnt;
        logic             level;
        logic             pp;
        logic             rp;
        logic             lp;

        assign active = ~s2;

        // Synchronizer, debounce FSM and long-press counter for one button.
        always_ff @(posedge clock) begin
            if (reset) begin
                s1    <= 1'b1;
                s2    <= 1'b1;
                state <= RELEASED;
                dcnt  <= '0;
                lcnt  <= '0;
                level <= 1'b0;
                pp    <= 1'b0;
                rp    <= 1'b0;
                lp    <= 1'b0;
            end else begin
                s1 <= button_l[i];
                s2 <= s1;
                pp <= 1'b0;
                rp <= 1'b0;
                lp <= 1'b0;
                case (state)
                    RELEASED: begin
                        if (active) begin
                            state <= PRESS_WAIT;
                            dcnt  <= CNT_W'(1);
                        end
                    end
                    PRESS_WAIT: begin
                        if (!active) begin
                            state <= RELEASED;
                            dcnt  <= '0;
                        end else if (dcnt == DB_LAST) begin
                            state <= PRESSED;
                            dcnt  <= '0;
                            lcnt  <= '0;
                            level <= 1'b1;
                            pp    <= 1'b1;
                        end else begin
                            dcnt <= dcnt + CNT_W'(1);
                        end
                    end
                    PRESSED: begin
                        // Saturation at LONG_MAX keeps the long pulse one-shot.
                        if (lcnt != LONG_MAX) begin
                            lcnt <= lcnt + CNT_W'(1);
                        end
                        if (lcnt == LONG_LAST) begin
                            lp <= 1'b1;
                        end
                        if (!active) begin
                            state <= RELEASE_WAIT;
                            dcnt  <= CNT_W'(1);
                        end
                    end
                    RELEASE_WAIT: begin
                        // lcnt is frozen here; a bounce resumes it uncleared.
                        if (active) begin
                            state <= PRESSED;
                            dcnt  <= '0;
                        end else if (dcnt == DB_LAST) begin
                            state <= RELEASED;
                            dcnt  <= '0;
                            level <= 1'b0;
                            rp    <= 1'b1;
                        end else begin
                            dcnt <= dcnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= RELEASED;
                        dcnt  <= '0;
                    end
                endcase
            end
        end

        assign pressed[i]       = level;
        assign press_pulse[i]   = pp;
        assign release_pulse[i] = rp;
        assign long_pulse[i]    = lp;
    end

endmodule
